dmem_sized_hs: RTL and testbench
================================

// Module: dmem_sized_hs
// PURPOSE
//   Second-generation data memory for the pipelined RISC-V core.
//   - Byte/half/word loads and stores, sign/zero extension, configurable read latency.
//   - Valid/ready request and response handshake; one transaction in flight.
//   - Misaligned, out-of-range and illegal-size accesses are flagged, not executed.
//   - Sits between the MEM stage and storage; replaces the single-cycle word-only DMEM.
// PARAMETERS
//   DATA_WIDTH  32   word width in bits; 32 only this generation (byte lanes = DATA_WIDTH/8)
//   MEM_SIZE    256  depth in words; need not be a power of two
//   ADDR_WIDTH  32   byte-address width
//   RD_LATENCY  1    cycles from read acceptance to rsp_valid; legal 1..8
// PORTS
//   clk           in   1           clock, rising edge
//   rst           in   1           async reset, active high
//   req_valid     in   1           request present
//   req_ready     out  1           block can accept a request
//   req_we        in   1           1 = store, 0 = load
//   req_size      in   2           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  in   1           load zero-extends when 1 (LBU/LHU), sign-extends when 0
//   req_addr      in   ADDR_WIDTH  byte address
//   req_wdata     in   DATA_WIDTH  store data, right-aligned (rs2)
//   rsp_valid     out  1           response present
//   rsp_ready     in   1           consumer takes response
//   rsp_rdata     out  DATA_WIDTH  load result, extended; 0 for stores and errors
//   rsp_err       out  1           access rejected
// BEHAVIOUR
//   Reset: state IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//     Memory contents are not reset.
//   Reset mid-transaction: return to IDLE immediately; drop any pending response.
//     A store already accepted stays committed.
//   FSM states: IDLE, BUSY, RESP.
//   - req_ready=1 only in IDLE. Accept = req_valid & req_ready at edge T.
//   - Accepted load, no error: IDLE->BUSY at T, counter loaded with RD_LATENCY-1.
//     Counter decrements each BUSY cycle; BUSY->RESP at the edge where it reads 0.
//     rsp_valid first high after edge T+RD_LATENCY.
//   - Store or error: IDLE->RESP at T; rsp_valid high after edge T.
//   - RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready.
//     RESP->IDLE on rsp_valid & rsp_ready; rsp_valid=0 next cycle.
//     No new request is taken in the same cycle as the response handshake.
//   Addressing: word index = req_addr >> 2; byte lane = req_addr[1:0]; little-endian.
//     Byte k occupies bits 8k+7:8k.
//   Errors (rsp_err=1, memory untouched, rsp_rdata=0):
//     - req_size = 11
//     - half access with addr[0]=1
//     - word access with addr[1:0]!=0
//     - word index >= MEM_SIZE
//   Store: committed at edge T, writing only the addressed lanes.
//     Byte: wdata[7:0] to lane; half: wdata[15:0] to lanes a, a+1; word: all lanes.
//     Other lanes keep their value.
//   Load: word read at acceptance, addressed lanes shifted to the LSBs, then extended.
//     A store cannot overlap a load because one transaction is in flight at a time.
//   Data path: load data is registered through the latency pipeline.
//     Address and size are captured at acceptance; later req_* changes are ignored.
// TESTING
//   1. Reset, SW 0xDEADBEEF @0x0, LW @0x0 -> rsp_rdata=0xDEADBEEF, rsp_err=0,
//      RD_LATENCY=1 rsp after T+1.
//   2. SB 0x7F @0x5, then LB @0x5 -> 0x0000007F; SB 0x80 @0x6, LB @0x6 -> 0xFFFFFF80,
//      LBU @0x6 -> 0x00000080.
//   3. Word @0x4 = 0x11223344, SH 0xABCD @0x6 -> word = 0xABCD3344; LH @0x6 -> 0xFFFFABCD.
//   4. LW @0x2, LH @0x1, size=11, LW @(MEM_SIZE*4) -> each rsp_err=1, rdata=0,
//      memory unchanged.
//   5. RD_LATENCY=4, rsp_ready low 3 cycles -> rsp_valid at T+4 held stable,
//      req_ready=0 until handshake.
//   6. Assert rst while in BUSY -> rsp_valid stays 0, req_ready=1 after reset,
//      next LW returns correct data.

Source files
------------

// File: rtl/dmem_sized_hs.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sized_hs
// Description : Data memory for the pipelined RISC-V core. Supports byte, half
//               and word loads and stores with sign or zero extension and a
//               configurable read latency. Requests and responses use a
//               valid/ready handshake, and only one transaction is in flight.
//               Misaligned, out-of-range and illegal-size accesses are
//               answered with rsp_err and are not executed.
// Ports       : clk, rst         - clock (rising edge), async reset (active high)
//               req_valid/ready  - request handshake
//               req_we           - 1 = store, 0 = load
//               req_size         - 00 byte, 01 half, 10 word, 11 illegal
//               req_unsigned     - zero-extend loads when 1
//               req_addr         - byte address
//               req_wdata        - store data, right-aligned
//               rsp_valid/ready  - response handshake
//               rsp_rdata        - extended load data (0 for stores/errors)
//               rsp_err          - access rejected
// Parameters  : DATA_WIDTH (32 only), MEM_SIZE (words, any depth >= 2),
//               ADDR_WIDTH (byte address), RD_LATENCY (1..8)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_sized_hs #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int c_lanes = DATA_WIDTH / 8;
    localparam int c_idx_w = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int c_cnt_w = 3;
    localparam logic [ADDR_WIDTH-3:0] c_mem_words = (ADDR_WIDTH-2)'(MEM_SIZE);
    localparam logic [c_cnt_w-1:0]    c_cnt_init  = c_cnt_w'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0]   r_load_data;

    logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];

    logic                    w_accept;
    logic [ADDR_WIDTH-3:0]   w_word_idx;
    logic [c_idx_w-1:0]      w_idx;
    logic [1:0]              w_lane;
    logic                    w_in_range;
    logic                    w_err;
    logic                    w_store;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic [DATA_WIDTH-1:0]   w_rd_shifted;
    logic [DATA_WIDTH-1:0]   w_load_data;
    logic [DATA_WIDTH-1:0]   w_wdata_sh;
    logic [c_lanes-1:0]      w_be;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    assign w_accept   = req_valid & r_req_ready;
    assign w_word_idx = req_addr[ADDR_WIDTH-1:2];
    assign w_idx      = w_word_idx[c_idx_w-1:0];
    assign w_lane     = req_addr[1:0];
    // Full-width compare so that high address bits beyond the index width
    // cannot alias back into the array.
    assign w_in_range = (w_word_idx < c_mem_words);

    always_comb begin
        w_err = 1'b0;
        case (req_size)
            2'b00:   w_err = 1'b0;
            2'b01:   w_err = req_addr[0];
            2'b10:   w_err = (req_addr[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
        if (!w_in_range) begin
            w_err = 1'b1;
        end
    end

    // Storage is read at acceptance; the index is only meaningful in range.
    assign w_rd_word    = w_in_range ? mem[w_idx] : '0;
    assign w_rd_shifted = w_rd_word >> {w_lane, 3'b000};

    always_comb begin
        w_load_data = '0;
        case (req_size)
            2'b00: w_load_data = req_unsigned
                ? {{(DATA_WIDTH-8){1'b0}}, w_rd_shifted[7:0]}
                : {{(DATA_WIDTH-8){w_rd_shifted[7]}}, w_rd_shifted[7:0]};
            2'b01: w_load_data = req_unsigned
                ? {{(DATA_WIDTH-16){1'b0}}, w_rd_shifted[15:0]}
                : {{(DATA_WIDTH-16){w_rd_shifted[15]}}, w_rd_shifted[15:0]};
            2'b10:   w_load_data = w_rd_word;
            default: w_load_data = '0;
        endcase
    end

    // Right-aligned store data is moved up to the addressed lane(s).
    assign w_wdata_sh = req_wdata << {w_lane, 3'b000};

    always_comb begin
        w_be = '0;
        case (req_size)
            2'b00:   w_be = c_lanes'(1) << w_lane;
            2'b01:   w_be = c_lanes'(3) << w_lane;
            2'b10:   w_be = '1;
            default: w_be = '0;
        endcase
    end

    // A request landing on the same edge as reset is not committed.
    assign w_store = w_accept & req_we & ~w_err & ~rst;

    // Storage has no reset: contents survive a reset, including stores
    // accepted just before it.
    always_ff @(posedge clk) begin
        if (w_store) begin
            for (int l = 0; l < c_lanes; l++) begin
                if (w_be[l]) begin
                    mem[w_idx][8*l +: 8] <= w_wdata_sh[8*l +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
            r_load_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        if (req_we || w_err) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= w_err;
                        end else begin
                            // Load data is captured now; later req_* changes
                            // have no effect on this transaction.
                            r_state     <= S_BUSY;
                            r_cnt       <= c_cnt_init;
                            r_load_data <= w_load_data;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_load_data;
                        r_rsp_err   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    // Back to IDLE only; a new request waits one more cycle.
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_sized_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_sized_hs
// Description : Scoreboard bench for dmem_sized_hs. Directed requests push
//               hand-computed responses; a monitor checks each response, its
//               latency and its stability while back-pressured.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_sized_hs;

    localparam int LAT   = 4;
    localparam int WORDS = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_sized_hs #(
        .DATA_WIDTH (32),
        .MEM_SIZE   (WORDS),
        .ADDR_WIDTH (32),
        .RD_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   cyc        = 0;
    int   n_vec      = 0;
    int   n_err      = 0;
    int   stall_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer: holds rsp_ready low for stall_left cycles of a presented response.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid && stall_left > 0) begin
                rsp_ready = 1'b0;
                stall_left--;
            end else begin
                rsp_ready = 1'b1;
            end
        end
    end

    // Monitor
    exp_t cur;
    bit   seen       = 1'b0;
    bit   expect_low = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            seen       = 1'b0;
            expect_low = 1'b0;
        end else if (expect_low) begin
            chk("valid_after_handshake", 32'(rsp_valid), 32'd0);
            expect_low = 1'b0;
        end else if (rsp_valid) begin
            if (!seen) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got rdata %h err %b expected no response", rsp_rdata, rsp_err);
                end else begin
                    cur = sbq[0];
                    chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    chk("rdata", rsp_rdata, cur.rdata);
                    chk("err", 32'(rsp_err), 32'(cur.err));
                    seen = 1'b1;
                end
            end else begin
                chk("rdata_hold", rsp_rdata, cur.rdata);
                chk("err_hold", 32'(rsp_err), 32'(cur.err));
            end
            chk("req_ready_in_rsp", 32'(req_ready), 32'd0);
            if (rsp_ready) begin
                if (seen) void'(sbq.pop_front());
                seen       = 1'b0;
                expect_low = 1'b1;
            end
        end
    end

    // Driver: present a request, wait (bounded) for acceptance, optionally
    // push the expected response, then scramble req_* after acceptance.
    task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input bit exp_e, input bit push);
        exp_t e;
        @(negedge clk);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1 for addr %h", a);
            req_valid = 1'b0;
        end else begin
            if (push) begin
                e.rdata = exp_d;
                e.err   = exp_e;
                e.lat   = (we || exp_e) ? 0 : LAT;
                e.acc   = cyc + 1;
                sbq.push_back(e);
            end
            @(posedge clk);
            #1;
            req_valid    = 1'b0;
            req_addr     = $urandom;
            req_wdata    = $urandom;
            req_size     = 2'($urandom_range(3));
            req_we       = 1'($urandom_range(1));
            req_unsigned = 1'($urandom_range(1));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;

        // Word store / load
        issue(1, 2'b10, 0, 32'h0, 32'hDEADBEEF, 32'h0, 0, 1);
        issue(0, 2'b10, 0, 32'h0, 32'h0, 32'hDEADBEEF, 0, 1);
        // Byte stores with sign / zero extension
        issue(1, 2'b00, 0, 32'h5, 32'hFFFFFF7F, 32'h0, 0, 1);
        issue(0, 2'b00, 0, 32'h5, 32'h0, 32'h0000007F, 0, 1);
        issue(1, 2'b00, 0, 32'h6, 32'h00000080, 32'h0, 0, 1);
        issue(0, 2'b00, 0, 32'h6, 32'h0, 32'hFFFFFF80, 0, 1);
        issue(0, 2'b00, 1, 32'h6, 32'h0, 32'h00000080, 0, 1);
        // Half store into upper lanes only
        issue(1, 2'b10, 0, 32'h4, 32'h11223344, 32'h0, 0, 1);
        issue(1, 2'b01, 0, 32'h6, 32'h5555ABCD, 32'h0, 0, 1);
        issue(0, 2'b10, 0, 32'h4, 32'h0, 32'hABCD3344, 0, 1);
        issue(0, 2'b01, 0, 32'h6, 32'h0, 32'hFFFFABCD, 0, 1);
        issue(0, 2'b01, 1, 32'h6, 32'h0, 32'h0000ABCD, 0, 1);
        issue(0, 2'b01, 0, 32'h4, 32'h0, 32'h00003344, 0, 1);
        issue(0, 2'b00, 0, 32'h7, 32'h0, 32'hFFFFFFAB, 0, 1);
        issue(0, 2'b00, 1, 32'h4, 32'h0, 32'h00000044, 0, 1);
        // Errors: loads and stores, memory must stay untouched
        issue(0, 2'b10, 0, 32'h2, 32'h0, 32'h0, 1, 1);
        issue(0, 2'b01, 0, 32'h1, 32'h0, 32'h0, 1, 1);
        issue(0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, 1);
        issue(0, 2'b10, 0, 32'(WORDS*4), 32'h0, 32'h0, 1, 1);
        issue(1, 2'b10, 0, 32'h2, 32'h01010101, 32'h0, 1, 1);
        issue(1, 2'b01, 0, 32'h3, 32'h02020202, 32'h0, 1, 1);
        issue(1, 2'b11, 0, 32'h0, 32'h03030303, 32'h0, 1, 1);
        issue(1, 2'b10, 0, 32'(WORDS*4), 32'h04040404, 32'h0, 1, 1);
        issue(0, 2'b10, 0, 32'h0, 32'h0, 32'hDEADBEEF, 0, 1);
        // Last valid word
        issue(1, 2'b10, 0, 32'((WORDS-1)*4), 32'hCAFEF00D, 32'h0, 0, 1);
        issue(0, 2'b10, 0, 32'((WORDS-1)*4), 32'h0, 32'hCAFEF00D, 0, 1);
        issue(0, 2'b01, 1, 32'((WORDS-1)*4 + 2), 32'h0, 32'h0000CAFE, 0, 1);
        // Back-pressure on a load and on a store response
        stall_left = 3;
        issue(0, 2'b10, 0, 32'h4, 32'h0, 32'hABCD3344, 0, 1);
        stall_left = 2;
        issue(1, 2'b00, 0, 32'h8, 32'h000000A5, 32'h0, 0, 1);

        // Reset while a load is in BUSY: its response must never appear
        issue(0, 2'b10, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("busy_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("busy_reset_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("post_reset_req_ready", 32'(req_ready), 32'd1);
        end
        issue(0, 2'b10, 0, 32'h0, 32'h0, 32'hDEADBEEF, 0, 1);

        // Store accepted right before reset stays committed
        issue(1, 2'b10, 0, 32'hC, 32'h12345678, 32'h0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(0, 2'b10, 0, 32'hC, 32'h0, 32'h12345678, 0, 1);
        issue(0, 2'b00, 1, 32'h8, 32'h0, 32'h000000A5, 0, 1);

        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
